// File: rtl/rob_pkg.sv
// Shared definitions for the AR ID ordering unit: tag pool sizing and the tag table entry layout.
package rob_pkg;

   localparam int NUM_TAGS    = 16;
   localparam int TAG_W       = $clog2(NUM_TAGS);
   localparam int ENTRY_ID_W  = 8;
   localparam int ENTRY_LEN_W = 8;

   typedef struct packed {
      logic                   valid;
      logic [ENTRY_ID_W-1:0]  orig_id;
      logic [ENTRY_LEN_W-1:0] len;
   } tag_entry_t;

endpackage

// File: rtl/ar_if.sv
// AXI read-address channel bundle shared between the request buffer, the ordering unit and the slave.
interface ar_if #(
   parameter int ID_WIDTH    = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int SIZE_WIDTH  = 3,
   parameter int BURST_WIDTH = 2,
   parameter int QOS_WIDTH   = 4
);
   // A beat transfers on the edge where valid & ready are both 1; once valid
   // rises, the sender holds every field stable until that edge.
   logic [ID_WIDTH-1:0]    id;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [LEN_WIDTH-1:0]   len;
   logic [SIZE_WIDTH-1:0]  size;
   logic [BURST_WIDTH-1:0] burst;
   logic [QOS_WIDTH-1:0]   qos;
   logic                   valid;
   logic                   ready;

   modport sender   (output id, addr, len, size, burst, qos, valid, input ready);
   modport receiver (input id, addr, len, size, burst, qos, valid, output ready);
endinterface

// File: rtl/ar_id_ordering_unit_free_tag_picker.sv
// Combinational lowest-index finder of a clear bit in the tag valid vector.
module free_tag_picker #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] i_valid_vec,
   output logic         o_found,
   output logic [W-1:0] o_idx
);
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      // Scan downward so the last hit written is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         if (!i_valid_vec[i]) begin
            o_found = 1'b1;
            o_idx   = W'(i);
         end
      end
   end
endmodule

// File: rtl/ar_id_ordering_unit.sv
// Remaps incoming AR IDs onto a pool of internal tags, tracking original ID and per-ID order.
module ar_id_ordering_unit #(
   parameter int ID_WIDTH    = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int SIZE_WIDTH  = 3,
   parameter int BURST_WIDTH = 2,
   parameter int QOS_WIDTH   = 4,
   parameter int NUM_TAGS    = rob_pkg::NUM_TAGS,
   localparam int TAG_W      = $clog2(NUM_TAGS)
) (
   input  logic                clk,
   input  logic                rst,
   ar_if.receiver              ar_in,
   ar_if.sender                ar_out,
   output logic                alloc_valid,
   output logic [TAG_W-1:0]    alloc_tag,
   output logic [ID_WIDTH-1:0] alloc_orig_id,
   output logic [TAG_W:0]      alloc_seq,
   input  logic                free_valid,
   input  logic [TAG_W-1:0]    free_tag,
   input  logic [TAG_W-1:0]    lookup_tag,
   output logic [ID_WIDTH-1:0] lookup_orig_id,
   output logic                tags_full,
   output logic [TAG_W:0]      outstanding,
   output logic                err_bad_free
);
   import rob_pkg::tag_entry_t;

   tag_entry_t              r_tab [NUM_TAGS];
   logic                    r_out_valid;
   logic [TAG_W-1:0]        r_out_tag;
   logic [ADDR_WIDTH-1:0]   r_out_addr;
   logic [LEN_WIDTH-1:0]    r_out_len;
   logic [SIZE_WIDTH-1:0]   r_out_size;
   logic [BURST_WIDTH-1:0]  r_out_burst;
   logic [QOS_WIDTH-1:0]    r_out_qos;
   logic [TAG_W:0]          r_outstanding;
   logic                    r_err;

   logic [NUM_TAGS-1:0]     w_valid_vec;
   logic                    w_found;
   logic [TAG_W-1:0]        w_free_idx;
   logic                    w_out_fire;
   logic                    w_in_ready;
   logic                    w_in_fire;
   logic                    w_free_ok;
   logic [TAG_W:0]          w_seq;
   logic                    w_unused_len;

   always_comb begin
      w_valid_vec  = '0;
      w_unused_len = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         w_valid_vec[i] = r_tab[i].valid;
         w_unused_len   = w_unused_len ^ (^r_tab[i].len);
      end
   end

   free_tag_picker #(.N(NUM_TAGS), .W(TAG_W)) u_picker (
      .i_valid_vec (w_valid_vec),
      .o_found     (w_found),
      .o_idx       (w_free_idx)
   );

   assign w_out_fire = r_out_valid & ar_out.ready;
   assign w_in_ready = w_found & (~r_out_valid | ar_out.ready);
   assign w_in_fire  = ar_in.valid & w_in_ready;
   // The tag sitting unsent in the output register cannot have completed yet.
   assign w_free_ok  = free_valid & r_tab[free_tag].valid
                       & ~(r_out_valid & (r_out_tag == free_tag));

   always_comb begin
      w_seq = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (r_tab[i].valid && (TAG_W'(i) != r_out_tag)
             && (r_tab[i].orig_id == r_tab[r_out_tag].orig_id))
            w_seq = w_seq + (TAG_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAGS; i++) r_tab[i].valid <= 1'b0;
         r_out_valid   <= 1'b0;
         r_outstanding <= '0;
         r_err         <= 1'b0;
      end else begin
         if (w_free_ok) r_tab[free_tag].valid <= 1'b0;
         if (w_in_fire) begin
            r_tab[w_free_idx].valid   <= 1'b1;
            r_tab[w_free_idx].orig_id <= ar_in.id;
            r_tab[w_free_idx].len     <= ar_in.len;
            r_out_tag   <= w_free_idx;
            r_out_addr  <= ar_in.addr;
            r_out_len   <= ar_in.len;
            r_out_size  <= ar_in.size;
            r_out_burst <= ar_in.burst;
            r_out_qos   <= ar_in.qos;
            r_out_valid <= 1'b1;
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
         case ({w_in_fire, w_free_ok})
            2'b10:   r_outstanding <= r_outstanding + (TAG_W+1)'(1);
            2'b01:   r_outstanding <= r_outstanding - (TAG_W+1)'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         if (free_valid && !w_free_ok) r_err <= 1'b1;
      end
   end

   assign ar_in.ready    = w_in_ready;
   assign ar_out.valid   = r_out_valid;
   assign ar_out.id      = {{(ID_WIDTH-TAG_W){1'b0}}, r_out_tag};
   assign ar_out.addr    = r_out_addr;
   assign ar_out.len     = r_out_len;
   assign ar_out.size    = r_out_size;
   assign ar_out.burst   = r_out_burst;
   assign ar_out.qos     = r_out_qos;

   assign alloc_valid    = w_out_fire;
   assign alloc_tag      = r_out_tag;
   assign alloc_orig_id  = r_tab[r_out_tag].orig_id;
   assign alloc_seq      = w_seq;
   assign lookup_orig_id = r_tab[lookup_tag].orig_id;
   assign outstanding    = r_outstanding;
   assign tags_full      = (r_outstanding == (TAG_W+1)'(NUM_TAGS));
   assign err_bad_free   = r_err;
endmodule

// File: doc/ar_id_ordering_unit.md
AR_ID_ORDERING_UNIT -- requirements
Module: ar_id_ordering_unit

Interface
REQ-001 Parameters (name, default, meaning): ID_WIDTH 8 AR ID width; ADDR_WIDTH 32; LEN_WIDTH 8; SIZE_WIDTH 3; BURST_WIDTH 2; QOS_WIDTH 4; NUM_TAGS 16 internal tags (power of 2, 2..ID_WIDTH-representable); TAG_W = log2(NUM_TAGS).
REQ-002 clk  in  1  single clock; reset is synchronous and active-high.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ar_in  ar_if.receiver  --  AR stream from the incoming request buffer (id, addr, len, size, burst, qos, valid, ready).
REQ-005 ar_out  ar_if.sender  --  remapped AR to slave; id carries tag, zero-extended to ID_WIDTH.
REQ-006 alloc_valid  out  1  one-cycle strobe, asserted with every ar_out handshake.
REQ-007 alloc_tag  out  TAG_W  tag of the AR handed off this cycle.
REQ-008 alloc_orig_id  out  ID_WIDTH  original master ID of that AR.
REQ-009 alloc_seq  out  TAG_W+1  number of older outstanding tags holding the same original ID.
REQ-010 free_valid / free_tag  in  1 / TAG_W  release of a tag whose last beat has completed.
REQ-011 lookup_tag  in  TAG_W; lookup_orig_id  out  ID_WIDTH  combinational tag->original-ID translation.
REQ-012 tags_full  out  1; outstanding  out  TAG_W+1; err_bad_free  out  1 (sticky).

Function
REQ-013 Tag table: NUM_TAGS entries {valid, orig_id, len}; a tag is allocated when its AR is captured into the output register.
REQ-014 Allocation picks the lowest-index tag with valid=0.
REQ-015 ar_in.ready = (any free tag) & (~out_valid_q | ar_out.ready).
REQ-016 On ar_in.valid & ar_in.ready: capture addr/len/size/burst/qos, set output id = tag, set out_valid_q, mark the tag valid, store orig_id and len; latency in->out is exactly 1 cycle.
REQ-017 ar_out.valid = out_valid_q; while valid & ~ready, all ar_out fields stay stable.
REQ-018 Back-to-back: with ar_out.ready=1 held, one AR passes per cycle.
REQ-019 alloc_* asserted in the cycle of ar_out.valid & ar_out.ready, taken from the output register.
REQ-020 alloc_seq = count of valid entries (excluding this tag) whose orig_id equals the output register's orig_id, sampled with the tag table as of that cycle's start, so frees landing that cycle do not reduce it.
REQ-021 Free: free_valid with a valid tag clears it on the next edge; the tag becomes allocatable no earlier than the next cycle (never in the same cycle).
REQ-022 Free of a tag with valid=0, or of the tag currently held unsent in the output register, is ignored and sets err_bad_free until reset.
REQ-023 Simultaneous allocate and free (necessarily different tags) both take effect; outstanding is unchanged.
REQ-024 outstanding = number of valid tags; tags_full = (outstanding == NUM_TAGS); ar_in.ready=0 when full.
REQ-025 lookup_orig_id returns stored orig_id regardless of the valid bit.

Reset
REQ-026 On rst at a clock edge: all tag valid bits 0, out_valid_q 0, alloc_valid 0, outstanding 0, tags_full 0, err_bad_free 0; stored orig_id/len/payload need no reset.
REQ-027 Reset mid-operation discards any captured, unsent AR and all allocations; ar_in.ready is 1 in the first cycle after reset.

Structure
REQ-028 Shared package rob_pkg holds NUM_TAGS, TAG_W, and the tag entry struct {valid, orig_id, len}.
REQ-029 One sub-module, free_tag_picker: combinational lowest-index-zero finder over the valid vector, outputting found and index.

Verification
REQ-030 Reset, then AR id=0x5A, ar_out.ready=1 -> next cycle ar_out.id=0x00, alloc_tag=0, alloc_orig_id=0x5A, alloc_seq=0, outstanding=1.
REQ-031 Three ARs id=0x07 back-to-back, no frees -> tags 0,1,2 and alloc_seq 0,1,2, one per cycle.
REQ-032 16 ARs, no frees -> tags_full=1, ar_in.ready=0; free_tag=3 -> next AR gets tag 3, one cycle after the free.
REQ-033 ar_out.ready=0 for 4 cycles with AR captured -> ar_out fields stable, ar_in.ready=0, no alloc_valid.
REQ-034 free_tag=9 when tag 9 unallocated -> err_bad_free=1 and stays 1; outstanding unchanged.
REQ-035 Assert rst with 5 outstanding and one unsent AR -> ar_out.valid=0, outstanding=0; next AR gets tag 0.
